uart_cfg_core: RTL and testbench

UART_CFG_CORE -- requirements
Module: uart_cfg_core

---
 rtl/uart_cfg_core.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_cfg_core.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_core.sv
// Configurable UART transmitter/receiver pair sharing one clock.
// TX and RX are fully independent; RX oversamples the line 16x per bit.
module uart_cfg_core #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 4800,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_busy,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int DIV     = CLK_FREQ / (BAUD_RATE * 16);
  localparam int BIT_CYC = 16 * DIV;
  localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  // Refuse to elaborate with a divisor too small to oversample or an illegal frame format
  generate
    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_cfg_core: illegal parameter combination");
    end
  endgenerate

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t              tx_state_reg, tx_state_next;
  logic [CW-1:0]          tx_cnt_reg, tx_cnt_next;
  logic [2:0]             tx_bit_reg, tx_bit_next;
  logic [DATA_BITS-1:0]   tx_shift_reg, tx_shift_next;
  logic                   tx_par_reg, tx_par_next;
  logic                   tx_out_reg, tx_out_next;
  logic                   tx_busy_reg, tx_busy_next;
  logic                   tx_bit_end;
  logic                   tx_accept;

  assign tx_bit_end = (tx_cnt_reg == CW'(BIT_CYC - 1));

  // TX state, bit timer and registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_out_reg   <= 1'b1;
      tx_busy_reg  <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_par_reg   <= tx_par_next;
      tx_out_reg   <= tx_out_next;
      tx_busy_reg  <= tx_busy_next;
    end
  end

  // TX next-state: a new frame may start from IDLE or in the very last stop-bit cycle,
  // so held tx_start yields back-to-back frames with no idle gap
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_bit_end ? '0 : tx_cnt_reg + CW'(1);
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_par_next   = tx_par_reg;
    tx_out_next   = tx_out_reg;
    tx_busy_next  = tx_busy_reg;
    tx_accept     = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_cnt_next = '0;
        tx_out_next = 1'b1;
        if (tx_start) tx_accept = 1'b1;
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_next = TX_DATA;
          tx_bit_next   = '0;
          tx_out_next   = tx_shift_reg[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_next = tx_shift_reg >> 1;
          if (tx_bit_reg == 3'(DATA_BITS - 1)) begin
            tx_bit_next = '0;
            if (PARITY != 0) begin
              tx_state_next = TX_PARITY;
              tx_out_next   = tx_par_reg;
            end else begin
              tx_state_next = TX_STOP;
              tx_out_next   = 1'b1;
            end
          end else begin
            tx_bit_next = tx_bit_reg + 3'd1;
            tx_out_next = tx_shift_reg[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_next = TX_STOP;
          tx_bit_next   = '0;
          tx_out_next   = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_bit_reg == 3'(STOP_BITS - 1)) begin
            if (tx_start) begin
              tx_accept = 1'b1;
            end else begin
              tx_state_next = TX_IDLE;
              tx_out_next   = 1'b1;
              tx_busy_next  = 1'b0;
            end
          end else begin
            tx_bit_next = tx_bit_reg + 3'd1;
          end
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
        tx_out_next   = 1'b1;
        tx_busy_next  = 1'b0;
      end
    endcase
    if (tx_accept) begin
      tx_state_next = TX_START;
      tx_cnt_next   = '0;
      tx_bit_next   = '0;
      tx_shift_next = tx_data;
      tx_par_next   = (^tx_data) ^ (PARITY == 1);
      tx_out_next   = 1'b0;
      tx_busy_next  = 1'b1;
    end
  end

  assign tx_out  = tx_out_reg;
  assign tx_busy = tx_busy_reg;

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  rx_state_t              rx_state_reg, rx_state_next;
  logic                   rx_meta_reg, rx_sync_reg;
  logic [DW-1:0]          rx_div_reg, rx_div_next;
  logic [3:0]             rx_tick_reg, rx_tick_next;
  logic [2:0]             rx_bit_reg, rx_bit_next;
  logic [DATA_BITS-1:0]   rx_shift_reg, rx_shift_next;
  logic                   rx_par_reg, rx_par_next;
  logic [DATA_BITS-1:0]   rx_data_reg, rx_data_next;
  logic                   rx_valid_reg, rx_valid_next;
  logic                   rx_perr_reg, rx_perr_next;
  logic                   rx_ferr_reg, rx_ferr_next;
  logic                   rx_tick;
  logic                   rx_bit_mid;

  assign rx_tick    = (rx_div_reg == DW'(DIV - 1));
  assign rx_bit_mid = rx_tick && (rx_tick_reg == 4'd15);

  // Two-flop synchroniser for the asynchronous serial input (idles high)
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_in;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // RX state, prescaler, tick counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg <= RX_IDLE;
      rx_div_reg   <= '0;
      rx_tick_reg  <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_par_reg   <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_perr_reg  <= 1'b0;
      rx_ferr_reg  <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_div_reg   <= rx_div_next;
      rx_tick_reg  <= rx_tick_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_par_reg   <= rx_par_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      rx_perr_reg  <= rx_perr_next;
      rx_ferr_reg  <= rx_ferr_next;
    end
  end

  // RX next-state: start mid-point after 8 ticks, then one sample every 16 ticks
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_div_next   = rx_tick ? '0 : rx_div_reg + DW'(1);
    rx_tick_next  = rx_tick ? rx_tick_reg + 4'd1 : rx_tick_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_par_next   = rx_par_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    rx_perr_next  = rx_perr_reg;
    rx_ferr_next  = rx_ferr_reg;
    case (rx_state_reg)
      RX_IDLE: begin
        if (!rx_sync_reg) begin
          rx_state_next = RX_START;
          rx_div_next   = '0;
          rx_tick_next  = '0;
        end
      end
      RX_START: begin
        if (rx_tick && rx_tick_reg == 4'd7) begin
          rx_tick_next  = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_mid) begin
          rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
          if (rx_bit_reg == 3'(DATA_BITS - 1)) begin
            rx_state_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_next = rx_bit_reg + 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_bit_mid) begin
          rx_par_next   = rx_sync_reg;
          rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_bit_mid) begin
          rx_valid_next = 1'b1;
          rx_data_next  = rx_shift_reg;
          rx_perr_next  = (PARITY != 0) && (rx_par_reg != ((^rx_shift_reg) ^ (PARITY == 1)));
          rx_ferr_next  = !rx_sync_reg;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_WAIT_IDLE;
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_sync_reg) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  assign rx_data       = rx_data_reg;
  assign rx_valid      = rx_valid_reg;
  assign rx_parity_err = rx_perr_reg;
  assign rx_frame_err  = rx_ferr_reg;

endmodule

// File: tb/tb_uart_cfg_core.sv
// Bench for uart_cfg_core: three instances (8N1, 8E1, 7O2) at DIV=10, BIT_CYC=160.
module tb_uart_cfg_core;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int BIT_CYC  = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] tx_start_v = 3'b000;
  logic [2:0] tx_out_v, tx_busy_v, rx_in_v, rx_valid_v, rx_perr_v, rx_ferr_v;
  logic [1:0] rx_drv = 2'b11;
  logic       loop_e = 1'b0;
  logic [7:0] tx_data_n = 8'h00, tx_data_e = 8'h00;
  logic [6:0] tx_data_o = 7'h00;
  logic [7:0] rx_data_n, rx_data_e;
  logic [6:0] rx_data_o;

  assign rx_in_v[0] = rx_drv[0];
  assign rx_in_v[1] = loop_e ? tx_out_v[1] : rx_drv[1];
  assign rx_in_v[2] = tx_out_v[2];

  uart_cfg_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst(rst), .tx_start(tx_start_v[0]), .tx_data(tx_data_n), .tx_out(tx_out_v[0]),
    .tx_busy(tx_busy_v[0]), .rx_in(rx_in_v[0]), .rx_data(rx_data_n), .rx_valid(rx_valid_v[0]),
    .rx_parity_err(rx_perr_v[0]), .rx_frame_err(rx_ferr_v[0]));

  uart_cfg_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst(rst), .tx_start(tx_start_v[1]), .tx_data(tx_data_e), .tx_out(tx_out_v[1]),
    .tx_busy(tx_busy_v[1]), .rx_in(rx_in_v[1]), .rx_data(rx_data_e), .rx_valid(rx_valid_v[1]),
    .rx_parity_err(rx_perr_v[1]), .rx_frame_err(rx_ferr_v[1]));

  uart_cfg_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_o (
    .clk(clk), .rst(rst), .tx_start(tx_start_v[2]), .tx_data(tx_data_o), .tx_out(tx_out_v[2]),
    .tx_busy(tx_busy_v[2]), .rx_in(rx_in_v[2]), .rx_data(rx_data_o), .rx_valid(rx_valid_v[2]),
    .rx_parity_err(rx_perr_v[2]), .rx_frame_err(rx_ferr_v[2]));

  int tests_run    = 0;
  int tests_failed = 0;

  // Received-frame log per instance
  int         vcnt[3] = '{0, 0, 0};
  logic [7:0] last_d[3];
  logic       last_pe[3], last_fe[3];
  logic [9:0] rxq_o[$];

  always @(negedge clk) begin
    if (rx_valid_v[0]) begin
      vcnt[0]++; last_d[0] = rx_data_n; last_pe[0] = rx_perr_v[0]; last_fe[0] = rx_ferr_v[0];
    end
    if (rx_valid_v[1]) begin
      vcnt[1]++; last_d[1] = rx_data_e; last_pe[1] = rx_perr_v[1]; last_fe[1] = rx_ferr_v[1];
    end
    if (rx_valid_v[2]) begin
      vcnt[2]++; rxq_o.push_back({rx_perr_v[2], rx_ferr_v[2], 1'b0, rx_data_o});
    end
  end

  // Reference frame: list of line bits for an instance's format (bit 0 sent first)
  function automatic int mk_frame(input int inst, input logic [7:0] d, input bit flip,
                                  input bit stop0, output logic [15:0] f);
    int n, db, pm, sb;
    logic p;
    db = (inst == 2) ? 7 : 8;
    pm = (inst == 0) ? 0 : ((inst == 1) ? 2 : 1);
    sb = (inst == 2) ? 2 : 1;
    f = '1;
    n = 0;
    p = 1'b0;
    f[n] = 1'b0; n++;
    for (int i = 0; i < db; i++) begin
      f[n] = d[i]; p = p ^ d[i]; n++;
    end
    if (pm != 0) begin
      f[n] = ((pm == 1) ? ~p : p) ^ flip; n++;
    end
    for (int s = 0; s < sb; s++) begin
      f[n] = !(stop0 && s == 0); n++;
    end
    return n;
  endfunction

  task automatic set_data(input int inst, input logic [7:0] d);
    case (inst)
      0: tx_data_n = d;
      1: tx_data_e = d;
      default: tx_data_o = d[6:0];
    endcase
  endtask

  // Send one frame through TX and compare every cycle of the line against the reference
  task automatic tx_frame_check(input int inst, input logic [7:0] d, input int poke_at, input bit rel_rst);
    logic [15:0] f;
    int len, bad, first_k;
    len = mk_frame(inst, d, 1'b0, 1'b0, f);
    bad = 0; first_k = -1;
    @(posedge clk); #1;
    if (rel_rst) rst = 1'b0;
    set_data(inst, d);
    tx_start_v[inst] = 1'b1;
    @(posedge clk); #1;
    tx_start_v[inst] = 1'b0;
    set_data(inst, ~d);
    for (int k = 0; k < len * BIT_CYC; k++) begin
      @(negedge clk);
      if (k == poke_at) tx_start_v[inst] = 1'b1;
      if (k == poke_at + 3) tx_start_v[inst] = 1'b0;
      if (tx_out_v[inst] !== f[k / BIT_CYC] || tx_busy_v[inst] !== 1'b1) begin
        if (bad == 0) first_k = k;
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL tx_wave inst%0d data=%h: %0d cycles wrong, first at cycle %0d (required %0d-cycle frame)",
               inst, d, bad, first_k, len * BIT_CYC);
    end
    @(negedge clk);
    tests_run++;
    if (tx_busy_v[inst] !== 1'b0 || tx_out_v[inst] !== 1'b1) begin
      tests_failed++;
      $display("FAIL tx_end inst%0d: busy=%b out=%b, required busy=0 out=1", inst, tx_busy_v[inst], tx_out_v[inst]);
    end
    $display("[TB] tx inst%0d data=%h len=%0d cycles", inst, d, len * BIT_CYC);
  endtask

  // Drive one frame onto an RX input directly
  task automatic rx_send(input int inst, input logic [7:0] d, input bit flip, input bit stop0, input logic end_level);
    logic [15:0] f;
    int len;
    len = mk_frame(inst, d, flip, stop0, f);
    for (int b = 0; b < len; b++) begin
      @(posedge clk); #1;
      rx_drv[inst] = f[b];
      repeat (BIT_CYC - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    rx_drv[inst] = end_level;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (tx_out_v !== 3'b111 || tx_busy_v !== 3'b000) begin
      tests_failed++; $display("FAIL reset_tx: out=%b busy=%b, required 111/000", tx_out_v, tx_busy_v);
    end
    tests_run++;
    if (rx_valid_v !== 3'b000 || rx_perr_v !== 3'b000 || rx_ferr_v !== 3'b000) begin
      tests_failed++; $display("FAIL reset_rx_flags: valid=%b perr=%b ferr=%b, required 000", rx_valid_v, rx_perr_v, rx_ferr_v);
    end
    tests_run++;
    if (rx_data_n !== 8'h00 || rx_data_e !== 8'h00 || rx_data_o !== 7'h00) begin
      tests_failed++; $display("FAIL reset_rx_data: %h %h %h, required 0", rx_data_n, rx_data_e, rx_data_o);
    end
    $display("[TB] reset checked");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_tx_8n1;
    tx_frame_check(0, 8'hA5, -1, 1'b0);
    for (int i = 0; i < 2; i++)
      tx_frame_check(0, 8'($urandom_range(0, 255)), int'($urandom_range(200, 1400)), 1'b0);
  endtask

  task automatic test_loopback_8e1;
    logic [7:0] d;
    int c0;
    loop_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 8'h3C : 8'($urandom_range(0, 255));
      c0 = vcnt[1];
      tx_frame_check(1, d, -1, 1'b0);
      repeat (5) @(negedge clk);
      tests_run++;
      if (vcnt[1] - c0 !== 1 || last_d[1] !== d || last_pe[1] !== 1'b0 || last_fe[1] !== 1'b0) begin
        tests_failed++;
        $display("FAIL loop_8e1: frames=%0d data=%h pe=%b fe=%b, required 1 %h 0 0", vcnt[1] - c0, last_d[1], last_pe[1], last_fe[1], d);
      end
      $display("[TB] loopback 8E1 data=%h", d);
    end
    loop_e = 1'b0;
  endtask

  task automatic test_parity_err;
    logic [7:0] d;
    int c0;
    c0 = vcnt[1];
    rx_send(1, 8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    tests_run++;
    if (vcnt[1] - c0 !== 1 || last_d[1] !== 8'h3C || last_pe[1] !== 1'b1 || last_fe[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_parity_err: frames=%0d data=%h pe=%b fe=%b, required 1 3c 1 0", vcnt[1] - c0, last_d[1], last_pe[1], last_fe[1]);
    end
    $display("[TB] rx 8E1 flipped parity data=3c");
    d = 8'($urandom_range(0, 255));
    rx_send(1, d, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    tests_run++;
    if (vcnt[1] - c0 !== 2 || last_d[1] !== d || last_pe[1] !== 1'b0 || last_fe[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_parity_ok: frames=%0d data=%h pe=%b fe=%b, required 2 %h 0 0", vcnt[1] - c0, last_d[1], last_pe[1], last_fe[1], d);
    end
    $display("[TB] rx 8E1 data=%h", d);
  endtask

  task automatic test_false_start;
    int c0;
    c0 = vcnt[0];
    @(posedge clk); #1; rx_drv[0] = 1'b0;
    repeat (50) @(posedge clk);
    #1; rx_drv[0] = 1'b1;
    repeat (400) @(negedge clk);
    tests_run++;
    if (vcnt[0] !== c0) begin
      tests_failed++; $display("FAIL false_start: %0d frames, required 0", vcnt[0] - c0);
    end
    rx_send(0, 8'h55, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    tests_run++;
    if (vcnt[0] - c0 !== 1 || last_d[0] !== 8'h55 || last_pe[0] !== 1'b0 || last_fe[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_false_start: frames=%0d data=%h pe=%b fe=%b, required 1 55 0 0", vcnt[0] - c0, last_d[0], last_pe[0], last_fe[0]);
    end
    $display("[TB] false start then rx data=55");
  endtask

  task automatic test_frame_err;
    logic [7:0] d;
    int c0;
    c0 = vcnt[0];
    rx_send(0, 8'h81, 1'b0, 1'b1, 1'b0);
    repeat (12 * BIT_CYC) @(negedge clk);
    tests_run++;
    if (vcnt[0] - c0 !== 1 || last_d[0] !== 8'h81 || last_pe[0] !== 1'b0 || last_fe[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL rx_frame_err: frames=%0d data=%h pe=%b fe=%b, required 1 81 0 1", vcnt[0] - c0, last_d[0], last_pe[0], last_fe[0]);
    end
    #1; rx_drv[0] = 1'b1;
    repeat (2 * BIT_CYC) @(posedge clk);
    d = 8'($urandom_range(0, 255));
    rx_send(0, d, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    tests_run++;
    if (vcnt[0] - c0 !== 2 || last_d[0] !== d || last_fe[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_frame_err: frames=%0d data=%h fe=%b, required 2 %h 0", vcnt[0] - c0, last_d[0], last_fe[0], d);
    end
    $display("[TB] frame error 81 then rx data=%h", d);
  endtask

  task automatic test_back_to_back;
    logic [7:0]  d[3];
    logic [15:0] f[3];
    int len, bad, first_k, per;
    for (int i = 0; i < 3; i++) begin
      d[i] = 8'($urandom_range(0, 127));
      len = mk_frame(2, d[i], 1'b0, 1'b0, f[i]);
    end
    per = len * BIT_CYC;
    rxq_o.delete();
    bad = 0; first_k = -1;
    @(posedge clk); #1;
    set_data(2, d[0]);
    tx_start_v[2] = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3 * per; k++) begin
      @(negedge clk);
      if (k % per == 800) begin
        if (k / per < 2) set_data(2, d[k / per + 1]);
        else tx_start_v[2] = 1'b0;
      end
      if (tx_out_v[2] !== f[k / per][(k % per) / BIT_CYC] || tx_busy_v[2] !== 1'b1) begin
        if (bad == 0) first_k = k;
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL b2b_wave: %0d cycles wrong, first at cycle %0d (required 3 gapless %0d-cycle frames)", bad, first_k, per);
    end
    @(negedge clk);
    tests_run++;
    if (tx_busy_v[2] !== 1'b0 || tx_out_v[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_end: busy=%b out=%b, required 0 1", tx_busy_v[2], tx_out_v[2]);
    end
    repeat (10) @(negedge clk);
    tests_run++;
    if (rxq_o.size() != 3) begin
      tests_failed++;
      $display("FAIL b2b_rx_count: %0d frames, required 3", rxq_o.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (rxq_o[i] !== {2'b00, d[i]}) begin
          tests_failed++;
          $display("FAIL b2b_rx%0d: {pe,fe,data}=%h, required %h", i, rxq_o[i], {2'b00, d[i]});
        end
      end
    end
    $display("[TB] back-to-back 7O2 data=%h %h %h", d[0], d[1], d[2]);
  endtask

  task automatic test_reset_mid;
    logic [15:0] f;
    int len, c0;
    c0 = vcnt[0];
    len = mk_frame(0, 8'hA5, 1'b0, 1'b0, f);
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin tx_data_n = 8'h3C; tx_start_v[0] = 1'b1; end
      if (c == 1) tx_start_v[0] = 1'b0;
      rx_drv[0] = f[c / BIT_CYC];
    end
    @(posedge clk); #1;
    rst = 1'b1;
    rx_drv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (tx_out_v[0] !== 1'b1 || tx_busy_v[0] !== 1'b0 || rx_valid_v[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_ctl: out=%b busy=%b valid=%b, required 1 0 0", tx_out_v[0], tx_busy_v[0], rx_valid_v[0]);
    end
    tests_run++;
    if (rx_data_n !== 8'h00 || rx_perr_v[0] !== 1'b0 || rx_ferr_v[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_rx: data=%h pe=%b fe=%b, required 00 0 0", rx_data_n, rx_perr_v[0], rx_ferr_v[0]);
    end
    $display("[TB] reset 500 cycles into frames");
    tx_frame_check(0, 8'hFF, -1, 1'b1);
    tests_run++;
    if (vcnt[0] !== c0) begin
      tests_failed++; $display("FAIL mid_reset_partial: %0d frames, required 0", vcnt[0] - c0);
    end
    rx_send(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    tests_run++;
    if (vcnt[0] - c0 !== 1 || last_d[0] !== 8'hFF || last_fe[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_rx_after: frames=%0d data=%h fe=%b, required 1 ff 0", vcnt[0] - c0, last_d[0], last_fe[0]);
    end
    $display("[TB] rx after reset data=ff");
  endtask

  initial begin
    test_reset();
    test_tx_8n1();
    test_loopback_8e1();
    test_parity_err();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
